tt_sweep_capture: RTL and testbench

- Characterises an N-input single-output combinational gate netlist (the ABC/yosys `gate` designs) by sweeping every input combination and sampling the output.
- Assembles the sampled outputs into the design's hex truth table. This is the inverse of synthesis, which turns a truth table into a netlist.
- Sits on the test harness beside a design under test (DUT) and reports the recovered truth table through a valid/ready result port, for comparison with the design's name (for example 0x4A32).

---
 rtl/tt_sweep_pkg.sv | 18 +
 rtl/tt_sweep_capture_timer.sv | 19 +
 rtl/tt_sweep_capture.sv | 107 ++++++++++
 tb/tb_tt_sweep_capture.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/tt_sweep_pkg.sv
// tt_sweep_pkg: shared state encoding and truth-table index helpers for tt_sweep_capture.
package tt_sweep_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_RESAMPLE,
    ST_DONE
  } state_e;
  function automatic int tt_width(input int n_in);
    return 1 << n_in;
  endfunction
  // Vector 0 (all inputs low) lands in the MSB, matching the hex gate names.
  function automatic int tt_bit_index(input int i, input int tt_w);
    return tt_w - 1 - i;
  endfunction
endpackage

// File: rtl/tt_sweep_capture_timer.sv
// tt_settle_timer: loadable down-counter; done_o pulses on the last enabled count.
module tt_settle_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else if (load_i) cnt_q <= load_val_i;
    else if (en_i && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  end
  assign done_o = en_i && cnt_q == W'(1);
endmodule

// File: rtl/tt_sweep_capture.sv
// tt_sweep_capture: sweeps every input vector of a gate netlist and recovers its hex truth table.
// Define TT_SWEEP_STABILITY_CHECK_EN to double-sample each vector and expose a sticky unstable flag.
module tt_sweep_capture
  import tt_sweep_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int SETTLE_CYCLES = 4,
  localparam int TT_W = tt_width(N_IN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            result_valid,
  input  logic            result_ready,
  output logic [TT_W-1:0] result_tt
`ifdef TT_SWEEP_STABILITY_CHECK_EN
  ,
  output logic            unstable
`endif
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
`ifdef TT_SWEEP_STABILITY_CHECK_EN
  localparam state_e LAST_ST = ST_RESAMPLE;
  logic s1_q, s1_d, unst_q, unst_d;
`else
  localparam state_e LAST_ST = ST_SAMPLE;
`endif
  state_e state_q, state_d;
  logic [N_IN:0] vec_q, vec_d;
  logic [TT_W-1:0] asm_q, asm_d, tt_q, tt_d;
  logic tmr_done, last, running, advance;
  assign last = vec_q == (N_IN + 1)'(TT_W - 1);
  assign running = state_q inside {ST_DRIVE, ST_SETTLE, ST_SAMPLE, ST_RESAMPLE};
  assign advance = state_q == LAST_ST && !abort;
  tt_settle_timer #(.W(CW)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (state_q == ST_DRIVE),
    .en_i      (state_q == ST_SETTLE),
    .load_val_i(CW'(SETTLE_CYCLES - 1)),
    .done_o    (tmr_done)
  );
  always_comb begin
    state_d = state_q;
    vec_d = vec_q;
    asm_d = asm_q;
    tt_d = tt_q;
    unique case (state_q)
      ST_IDLE:     state_d = start ? ST_DRIVE : ST_IDLE;
      ST_DRIVE:    state_d = SETTLE_CYCLES == 1 ? ST_SAMPLE : ST_SETTLE;
      ST_SETTLE:   state_d = tmr_done ? ST_SAMPLE : ST_SETTLE;
`ifdef TT_SWEEP_STABILITY_CHECK_EN
      ST_SAMPLE:   state_d = ST_RESAMPLE;
      ST_RESAMPLE: state_d = last ? ST_DONE : ST_DRIVE;
`else
      ST_SAMPLE:   state_d = last ? ST_DONE : ST_DRIVE;
`endif
      ST_DONE:     state_d = result_ready ? ST_IDLE : ST_DONE;
      default:     state_d = ST_IDLE;
    endcase
    if (running && abort) state_d = ST_IDLE;
    if (state_q == LAST_ST) asm_d[N_IN'(tt_bit_index(int'(vec_q), TT_W))] = dut_out;
    if (advance && !last) vec_d = vec_q + 1'b1;
    // The visible result only moves on a completed sweep, so aborts leave it intact.
    if (advance && last) tt_d = asm_d;
    if (state_d == ST_IDLE) vec_d = '0;
  end
`ifdef TT_SWEEP_STABILITY_CHECK_EN
  always_comb begin
    s1_d = state_q == ST_SAMPLE ? dut_out : s1_q;
    unst_d = unst_q;
    if (state_q == ST_IDLE && start) unst_d = 1'b0;
    if (state_q == ST_RESAMPLE && dut_out != s1_q) unst_d = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      unst_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      unst_q <= unst_d;
    end
  end
  assign unstable = unst_q;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q <= '0;
      asm_q <= '0;
      tt_q <= '0;
    end else begin
      state_q <= state_d;
      vec_q <= vec_d;
      asm_q <= asm_d;
      tt_q <= tt_d;
    end
  end
  assign dut_in = vec_q[N_IN-1:0];
  assign busy = running;
  assign result_valid = state_q == ST_DONE;
  assign result_tt = tt_q;
endmodule

// File: tb/tb_tt_sweep_capture.sv
// tb_tt_sweep_capture: table-driven and randomized sweeps against a gate-function reference model.
module tb_tt_sweep_capture;
  localparam int N = 4;
  localparam int S = 4;
  localparam int TW = 16;
`ifdef TT_SWEEP_STABILITY_CHECK_EN
  localparam int LAT = TW * (S + 2) + 1;
`else
  localparam int LAT = TW * (S + 1) + 1;
`endif
  logic clk = 0, rst_n = 0, start = 0, abort = 0, result_ready = 0, flip = 0;
  logic [N-1:0] dut_in;
  logic dut_out, busy, result_valid;
  logic [TW-1:0] result_tt;
  logic unstable;
  int mode = 0;
  logic [15:0] lut = '0, m1 = '0, m2 = '0, m3 = '0;
  int n_chk = 0, n_pass = 0;
  typedef struct {
    int m;
    logic [15:0] lut;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[7];

  always #5 clk = ~clk;

  tt_sweep_capture #(.N_IN(N), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_in(dut_in),
    .dut_out(dut_out), .busy(busy), .result_valid(result_valid),
    .result_ready(result_ready), .result_tt(result_tt)
`ifdef TT_SWEEP_STABILITY_CHECK_EN
    , .unstable(unstable)
`endif
  );
`ifndef TT_SWEEP_STABILITY_CHECK_EN
  assign unstable = 1'b0;
`endif

  // x[3] is gate input _0, x[0] is _3.
  function automatic logic gate(input int m, input logic [3:0] x);
    logic [15:0] t;
    t = lut >> (4'd15 - x);
    case (m)
      0: return t[0];
      1: return 1'b1;
      2: return 1'b0;
      3: return x[3];
      4: return x[0];
      5: return ^x;
      6: return &x;
      default: return ((x & m1[3:0]) == m2[3:0]) | (^(x & m3[3:0]));
    endcase
  endfunction

  assign dut_out = gate(mode, dut_in) ^ flip;

  function automatic logic [15:0] model(input int m);
    logic [15:0] t = '0;
    for (int i = 0; i < TW; i++) t[TW-1-i] = gate(m, 4'(i));
    return t;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic sweep(input string nm, input logic [15:0] exp_tt, input int flip_cyc,
                       input logic exp_unst, input logic accept);
    int cyc = 0;
    int bad_busy = 0;
    @(negedge clk); start = 1;
    @(posedge clk); #1 start = 0;
    while (cyc < LAT + 20) begin
      @(negedge clk); cyc++;
      if (result_valid) break;
      if (busy !== 1'b1) bad_busy++;
      if (flip_cyc != 0 && cyc == flip_cyc) begin @(posedge clk); #1 flip = 1; end
      else if (flip_cyc != 0 && cyc == flip_cyc + 1) begin @(posedge clk); #1 flip = 0; end
    end
    check({nm, " latency"}, cyc, LAT);
    check({nm, " busy during sweep"}, bad_busy, 0);
    check({nm, " busy at done"}, {31'b0, busy}, 0);
    check({nm, " result_tt"}, {16'b0, result_tt}, {16'b0, exp_tt});
`ifdef TT_SWEEP_STABILITY_CHECK_EN
    check({nm, " unstable"}, {31'b0, unstable}, {31'b0, exp_unst});
`endif
    if (accept) begin
      result_ready = 1;
      @(posedge clk); #1 result_ready = 0;
      @(negedge clk);
      check({nm, " idle after accept"}, {27'b0, result_valid, dut_in}, 0);
    end
  endtask

  initial begin
    int bad;
    int cyc;
    logic [15:0] e;
    tbl = '{'{0, 16'h4A32, 16'h4A32}, '{1, 16'h0, 16'hFFFF}, '{2, 16'h0, 16'h0000},
            '{3, 16'h0, 16'h00FF}, '{4, 16'h0, 16'h5555}, '{5, 16'h0, 16'h6996},
            '{6, 16'h0, 16'h0001}};
    #1;
    check("reset outputs", {11'b0, busy, result_valid, unstable, dut_in, result_tt}, 0);
    @(negedge clk); rst_n = 1;
    foreach (tbl[k]) begin
      mode = tbl[k].m;
      lut = tbl[k].lut;
      sweep($sformatf("table%0d", k), tbl[k].exp, 0, 1'b0, 1'b1);
    end
    // Result held against a stalled consumer while start pulses are ignored.
    mode = 0; lut = 16'h4A32;
    sweep("hold", 16'h4A32, 0, 1'b0, 1'b0);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (result_tt !== 16'h4A32 || dut_in !== 4'hF || result_valid !== 1'b1 || busy !== 1'b0) bad++;
      start = (k % 5 == 0);
    end
    start = 0;
    check("hold stable", bad, 0);
    @(negedge clk); result_ready = 1; start = 1;
    @(posedge clk); #1 result_ready = 0; start = 0;
    @(negedge clk);
    check("start dropped at accept", {30'b0, result_valid, busy}, 0);
    start = 1;
    @(posedge clk); #1 start = 0;
    @(negedge clk);
    check("restart accepted", {31'b0, busy}, 1);
    // Abort during cycle 30 of this sweep.
    cyc = 1;
    while (cyc < 30) begin @(negedge clk); cyc++; end
    abort = 1;
    @(posedge clk); #1 abort = 0;
    @(negedge clk);
    check("abort idle", {26'b0, busy, result_valid, dut_in}, 0);
    bad = 0;
    for (int k = 0; k < 100; k++) begin @(negedge clk); if (result_valid !== 1'b0) bad++; end
    check("no valid after abort", bad, 0);
    check("tt kept after abort", {16'b0, result_tt}, 32'h4A32);
    mode = 3;
    sweep("post-abort", 16'h00FF, 0, 1'b0, 1'b1);
    // Asynchronous reset mid-sweep.
    mode = 0;
    @(negedge clk); start = 1;
    @(posedge clk); #1 start = 0;
    for (int k = 0; k < 40; k++) @(negedge clk);
    #2 rst_n = 0;
    #1 check("async reset", {11'b0, busy, result_valid, unstable, dut_in, result_tt}, 0);
    @(negedge clk); rst_n = 1;
    sweep("post-reset", 16'h4A32, 0, 1'b0, 1'b1);
    for (int r = 0; r < 10; r++) begin
      mode = 7;
      m1 = 16'($urandom); m2 = 16'($urandom); m3 = 16'($urandom);
      e = model(7);
      sweep($sformatf("rand%0d", r), e, 0, 1'b0, 1'b1);
    end
`ifdef TT_SWEEP_STABILITY_CHECK_EN
    mode = 0; lut = 16'h4A32;
    sweep("glitch v5", 16'h4A32 ^ 16'h0400, 35, 1'b1, 1'b1);
    sweep("clean", 16'h4A32, 0, 1'b0, 1'b1);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
